matriz_mult_ctrl: RTL and testbench

- Front-end and back-end controller for the 5x5 int8 matrix multiplier.
- Accepts matrices A then B as a row-major byte stream with valid/ready, and packs them into the multiplier's 200-bit operand buses.
- Holds the multiplier's start high until it reports done, captures the 200-bit product and the overflow flag, then streams C back out row-major with valid/ready.
- Sits between the coprocessor instruction/memory path and the multiplier in the ULA.

---
 rtl/matriz_pkg.sv | 27 ++
 rtl/matriz_pack_unpack.sv | 55 +++++
 rtl/matriz_mult_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_matriz_mult_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matriz_pkg.sv
// Shared definitions for the 5x5 int8 matrix multiplier controller:
// geometry constants, controller state encoding and element packing.
package matriz_pkg;

    localparam int DIM      = 5;
    localparam int ELEM_W   = 8;
    localparam int NUM_ELEM = DIM * DIM;
    localparam int MAT_W    = NUM_ELEM * ELEM_W;
    localparam int IDX_W    = 5;

    localparam logic [IDX_W-1:0] FIRST_IDX = 5'd0;
    localparam logic [IDX_W-1:0] LAST_IDX  = 5'd24;

    typedef enum logic [2:0] {
        FLUSH  = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4
    } state_t;

    // Bit offset of stream element idx (idx = r*DIM + c) inside a packed matrix.
    function automatic int elem_offset(input int idx);
        return (idx / DIM) * DIM * ELEM_W + (idx % DIM) * ELEM_W;
    endfunction

endpackage

// File: rtl/matriz_pack_unpack.sv
// 200-bit matrix register with a byte-write port, a whole-matrix load port
// and a byte-read port, all indexed by stream element number 0..24.
module matriz_pack_unpack
    import matriz_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ELEM_W-1:0] wr_data,
    input  logic              load_en,
    input  logic [MAT_W-1:0]  load_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [MAT_W-1:0]  mat,
    output logic [ELEM_W-1:0] rd_data
);

    logic [MAT_W-1:0] mat_r;
    logic [MAT_W-1:0] mat_next_s;

    // Next matrix value: whole load wins over a single byte write.
    always_comb begin
        mat_next_s = mat_r;
        if (load_en) begin
            mat_next_s = load_data;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                mat_next_s[elem_offset(i) +: ELEM_W] =
                    (wr_idx == IDX_W'(i)) ? wr_data : mat_r[elem_offset(i) +: ELEM_W];
            end
        end else begin
            mat_next_s = mat_r;
        end
    end

    // Byte read mux; out-of-range indices read as zero.
    always_comb begin
        rd_data = {ELEM_W{1'b0}};
        for (int i = 0; i < NUM_ELEM; i++) begin
            rd_data = (rd_idx == IDX_W'(i)) ? mat_r[elem_offset(i) +: ELEM_W] : rd_data;
        end
    end

    // Matrix storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mat_r <= {MAT_W{1'b0}};
        end else begin
            mat_r <= mat_next_s;
        end
    end

    assign mat = mat_r;

endmodule

// File: rtl/matriz_mult_ctrl.sv
// Stream front/back end for the 5x5 int8 matrix multiplier: collects A and B
// as a byte stream, runs the multiplier, and streams the product C back out.
module matriz_mult_ctrl
    import matriz_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              ovf,
    output logic              busy,
    output logic [MAT_W-1:0]  mult_matriz_a,
    output logic [MAT_W-1:0]  mult_matriz_b,
    output logic              mult_start,
    input  logic [MAT_W-1:0]  mult_matriz_c,
    input  logic              mult_done,
    input  logic              mult_overflow
);

    state_t            state_r;
    logic [IDX_W-1:0]  k_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [ELEM_W-1:0] out_data_r;
    logic              ovf_r;
    logic              busy_r;
    logic              mult_start_r;

    logic              a_wr_en_s;
    logic              b_wr_en_s;
    logic              c_load_en_s;
    logic [IDX_W-1:0]  c_rd_idx_s;
    logic [ELEM_W-1:0] c_rd_data_s;
    logic [ELEM_W-1:0] unused_rd_a_s;
    logic [ELEM_W-1:0] unused_rd_b_s;
    logic [MAT_W-1:0]  unused_mat_c_s;

    assign a_wr_en_s   = (state_r == LOAD_A) && in_valid && in_ready_r;
    assign b_wr_en_s   = (state_r == LOAD_B) && in_valid && in_ready_r;
    assign c_load_en_s = (state_r == RUN) && mult_done;
    // out_data is registered, so the mux looks one element ahead.
    assign c_rd_idx_s  = k_r + 5'd1;

    matriz_pack_unpack u_mat_a (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (a_wr_en_s),
        .wr_idx    (k_r),
        .wr_data   (in_data),
        .load_en   (1'b0),
        .load_data ({MAT_W{1'b0}}),
        .rd_idx    (k_r),
        .mat       (mult_matriz_a),
        .rd_data   (unused_rd_a_s)
    );

    matriz_pack_unpack u_mat_b (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (b_wr_en_s),
        .wr_idx    (k_r),
        .wr_data   (in_data),
        .load_en   (1'b0),
        .load_data ({MAT_W{1'b0}}),
        .rd_idx    (k_r),
        .mat       (mult_matriz_b),
        .rd_data   (unused_rd_b_s)
    );

    matriz_pack_unpack u_mat_c (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr_en     (1'b0),
        .wr_idx    (k_r),
        .wr_data   ({ELEM_W{1'b0}}),
        .load_en   (c_load_en_s),
        .load_data (mult_matriz_c),
        .rd_idx    (c_rd_idx_s),
        .mat       (unused_mat_c_s),
        .rd_data   (c_rd_data_s)
    );

    // Controller FSM with all handshake and multiplier outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= FLUSH;
            k_r          <= FIRST_IDX;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            out_data_r   <= {ELEM_W{1'b0}};
            ovf_r        <= 1'b0;
            busy_r       <= 1'b1;
            mult_start_r <= 1'b0;
        end else begin
            case (state_r)
                FLUSH: begin
                    // The multiplier has no reset: run it to done once so its
                    // row index is back at 0, and drop whatever it produced.
                    if (mult_done) begin
                        mult_start_r <= 1'b0;
                        in_ready_r   <= 1'b1;
                        busy_r       <= 1'b0;
                        k_r          <= FIRST_IDX;
                        state_r      <= LOAD_A;
                    end else begin
                        mult_start_r <= 1'b1;
                    end
                end
                LOAD_A: begin
                    if (in_valid && in_ready_r) begin
                        busy_r <= 1'b1;
                        if (k_r == LAST_IDX) begin
                            k_r     <= FIRST_IDX;
                            state_r <= LOAD_B;
                        end else begin
                            k_r <= k_r + 5'd1;
                        end
                    end
                end
                LOAD_B: begin
                    if (in_valid && in_ready_r) begin
                        if (k_r == LAST_IDX) begin
                            k_r          <= FIRST_IDX;
                            in_ready_r   <= 1'b0;
                            mult_start_r <= 1'b1;
                            state_r      <= RUN;
                        end else begin
                            k_r <= k_r + 5'd1;
                        end
                    end
                end
                RUN: begin
                    // start stays high until done so the row index ends at 0.
                    if (mult_done) begin
                        mult_start_r <= 1'b0;
                        ovf_r        <= mult_overflow;
                        out_valid_r  <= 1'b1;
                        out_data_r   <= mult_matriz_c[ELEM_W-1:0];
                        out_last_r   <= 1'b0;
                        state_r      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (k_r == LAST_IDX) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            k_r         <= FIRST_IDX;
                            in_ready_r  <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= LOAD_A;
                        end else begin
                            k_r        <= k_r + 5'd1;
                            out_data_r <= c_rd_data_s;
                            out_last_r <= (k_r == (LAST_IDX - 5'd1));
                        end
                    end
                end
                default: begin
                    state_r      <= FLUSH;
                    k_r          <= FIRST_IDX;
                    in_ready_r   <= 1'b0;
                    out_valid_r  <= 1'b0;
                    out_last_r   <= 1'b0;
                    mult_start_r <= 1'b0;
                    busy_r       <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_last   = out_last_r;
    assign out_data   = out_data_r;
    assign ovf        = ovf_r;
    assign busy       = busy_r;
    assign mult_start = mult_start_r;

endmodule

// File: tb/tb_matriz_mult_ctrl.sv
// Self-checking bench for matriz_mult_ctrl with a behavioural row-per-cycle
// multiplier model and a byte scoreboard for the C stream.
module tb_matriz_mult_ctrl;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         ovf;
    logic         busy;
    logic [199:0] mult_matriz_a;
    logic [199:0] mult_matriz_b;
    logic         mult_start;
    logic [199:0] mult_matriz_c;
    logic         mult_done;
    logic         mult_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf;

    // Multiplier model: no reset, one row per cycle while start is high,
    // done pulse after row 4, start ignored during the done cycle.
    int           m_row  = 3;
    logic         m_done = 1'b0;
    logic [199:0] m_c    = '0;
    logic         m_ovf  = 1'b0;
    int           m_adv  = 0;

    always #5 clock = ~clock;

    matriz_mult_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .ovf           (ovf),
        .busy          (busy),
        .mult_matriz_a (mult_matriz_a),
        .mult_matriz_b (mult_matriz_b),
        .mult_start    (mult_start),
        .mult_matriz_c (mult_matriz_c),
        .mult_done     (mult_done),
        .mult_overflow (mult_overflow)
    );

    assign mult_matriz_c = m_c;
    assign mult_done     = m_done;
    assign mult_overflow = m_ovf;

    function automatic logic [200:0] matmul(input logic [199:0] a, input logic [199:0] b);
        logic [199:0] c;
        logic         o;
        int           s;
        c = '0;
        o = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int cc = 0; cc < 5; cc++) begin
                s = 0;
                for (int j = 0; j < 5; j++) begin
                    s += $signed(a[(r*5+j)*8 +: 8]) * $signed(b[(j*5+cc)*8 +: 8]);
                end
                c[(r*5+cc)*8 +: 8] = s[7:0];
                if (s > 127 || s < -128) o = 1'b1;
            end
        end
        return {o, c};
    endfunction

    always @(posedge clock) begin
        logic [200:0] res;
        if (mult_start && !m_done) begin
            m_adv <= m_adv + 1;
            if (m_row == 4) begin
                res    = matmul(mult_matriz_a, mult_matriz_b);
                m_row  <= 0;
                m_done <= 1'b1;
                m_c    <= res[199:0];
                m_ovf  <= res[200];
            end else begin
                m_row  <= m_row + 1;
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Push expected C bytes, then stream A and B into the DUT.
    task automatic send_op(input logic [199:0] a, input logic [199:0] b);
        logic [200:0] res;
        int           i;
        int           guard;
        logic         acc;
        res = matmul(a, b);
        for (int k = 0; k < 25; k++) exp_q.push_back(res[k*8 +: 8]);
        exp_ovf = res[200];
        i = 0;
        guard = 0;
        while (i < 50 && guard < 500) begin
            in_valid = 1'b1;
            in_data  = (i < 25) ? a[i*8 +: 8] : b[(i-25)*8 +: 8];
            acc      = in_ready;
            step();
            guard++;
            if (acc) i++;
        end
        in_valid = 1'b0;
        tests_run++;
        if (i !== 50) begin
            tests_failed++;
            $display("FAIL send_op: accepted %0d bytes, required 50", i);
        end
    endtask

    // Count cycles from the last B accept to the first out_valid.
    task automatic wait_output(output int lat);
        lat = 0;
        tests_run++;
        if (mult_start !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL run_entry: mult_start=%b in_ready=%b, required 1 0", mult_start, in_ready);
        end
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // Drain C, comparing against the scoreboard on every valid cycle.
    task automatic recv(input int mode, input int stop_after, output int hs);
        logic [3:0] pat;
        logic       rdy;
        int         cyc;
        pat = 4'b1001;
        hs  = 0;
        cyc = 0;
        while (hs < stop_after && cyc < 400) begin
            rdy = (mode == 0) ? 1'b1 : pat[3 - (cyc % 4)];
            out_ready = rdy;
            if (out_valid) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL c_extra: got 0x%02h with no byte expected", out_data);
                end else if (out_data !== exp_q[0] || out_last !== (exp_q.size() == 1) || ovf !== exp_ovf) begin
                    tests_failed++;
                    $display("FAIL c_elem%0d: data=0x%02h last=%b ovf=%b, required 0x%02h %b %b",
                             25 - exp_q.size(), out_data, out_last, ovf, exp_q[0], exp_q.size() == 1, exp_ovf);
                end
                if (rdy) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    hs++;
                end
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        if (stop_after == 25) begin
            tests_run++;
            if (hs !== 25 || exp_q.size() !== 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL drain_end: hs=%0d left=%0d valid=%b in_ready=%b busy=%b, required 25 0 0 1 0",
                         hs, exp_q.size(), out_valid, in_ready, busy);
            end
        end
    endtask

    // Release reset and wait for FLUSH to finish.
    task automatic wait_flush(output int cycles);
        reset_n = 1'b1;
        cycles  = 0;
        while (!in_ready && cycles < 30) begin
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL flush_no_output: out_valid=%b, required 0", out_valid);
            end
            step();
            cycles++;
        end
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || mult_start !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_exit: in_ready=%b busy=%b start=%b, required 1 0 0", in_ready, busy, mult_start);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || ovf !== 1'b0 ||
            mult_start !== 1'b0 || out_data !== 8'h00 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: rdy=%b val=%b last=%b ovf=%b start=%b data=0x%02h busy=%b, required 0 0 0 0 0 0x00 1",
                     tag, in_ready, out_valid, out_last, ovf, mult_start, out_data, busy);
        end
    endtask

    function automatic logic [199:0] identity();
        logic [199:0] m;
        m = '0;
        for (int i = 0; i < 5; i++) m[(i*6)*8 +: 8] = 8'h01;
        return m;
    endfunction

    function automatic logic [199:0] ramp();
        logic [199:0] m;
        for (int i = 0; i < 25; i++) m[i*8 +: 8] = 8'(i);
        return m;
    endfunction

    task automatic test_reset();
        int cyc;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        step();
        m_adv = 0;
        check_reset_outputs("reset_state");
        tests_run++;
        if (mult_matriz_a !== 200'd0 || mult_matriz_b !== 200'd0) begin
            tests_failed++;
            $display("FAIL reset_operands: a=%0h b=%0h, required 0 0", mult_matriz_a, mult_matriz_b);
        end
        wait_flush(cyc);
        tests_run++;
        if (m_adv !== 2 || cyc > 5) begin
            tests_failed++;
            $display("FAIL flush_len: start samples=%0d cycles=%0d, required 2 and <=5", m_adv, cyc);
        end
    endtask

    task automatic test_identity();
        int lat;
        int hs;
        send_op(identity(), ramp());
        wait_output(lat);
        tests_run++;
        if (lat !== 6) begin
            tests_failed++;
            $display("FAIL latency: %0d cycles, required 6", lat);
        end
        recv(0, 25, hs);
    endtask

    task automatic test_const(input logic [7:0] av, input logic [7:0] bv, input int mode);
        int lat;
        int hs;
        logic [199:0] a;
        logic [199:0] b;
        a = {25{av}};
        b = {25{bv}};
        send_op(a, b);
        wait_output(lat);
        recv(mode, 25, hs);
    endtask

    task automatic test_reset_in_run();
        int cyc;
        send_op(identity(), ramp());
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_run");
        exp_q.delete();
        step();
        wait_flush(cyc);
    endtask

    task automatic test_reset_in_drain();
        int lat;
        int hs;
        int cyc;
        test_const(8'h7F, 8'h7F, 2);
        send_op({25{8'h7F}}, {25{8'h7F}});
        wait_output(lat);
        recv(0, 10, hs);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_drain");
        exp_q.delete();
        step();
        wait_flush(cyc);
    endtask

    initial begin
        test_reset();
        test_identity();
        test_const(8'h02, 8'h03, 0);
        test_const(8'h7F, 8'h7F, 0);
        test_const(8'hFF, 8'h01, 1);
        test_reset_in_run();
        test_identity();
        test_reset_in_drain();
        test_identity();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
